arm7tdmi_exception_entry: RTL and testbench

Multi-cycle exception entry sequencer directly downstream of the exception priority/CPSR block. It consumes the selected exception (type, mode, vector, new CPSR, old CPSR) and performs architectural entry in order: bank SPSR and CPSR, write LR_<mode>, load PC with the vector, flush the pipeline, then wait for refill. While it runs, the core is stalled. Entry completion is reported back to the interrupt/abort sources.

---
 rtl/arm7tdmi_exception_entry_pkg.sv | 40 ++++
 rtl/arm7tdmi_exception_entry_if.sv | 51 +++++
 rtl/arm7tdmi_exception_entry_lr_calc.sv | 26 ++
 rtl/arm7tdmi_exception_entry.sv | 181 ++++++++++++++++++
 tb/tb_arm7tdmi_exception_entry.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm7tdmi_exception_entry_pkg.sv
// Shared types and constants for the exception entry sequencer.
package arm7tdmi_exception_entry_pkg;

  // Exception codes as produced by the priority/CPSR block; 0 means "none".
  typedef enum logic [2:0] {
    EXC_NONE = 3'd0,
    EXC_UND  = 3'd1,
    EXC_SWI  = 3'd2,
    EXC_PABT = 3'd3,
    EXC_DABT = 3'd4,
    EXC_IRQ  = 3'd5,
    EXC_FIQ  = 3'd6
  } exception_type_t;

  // Entry sequencer states, in the order they are visited.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAVE   = 3'd1,
    ST_LINK   = 3'd2,
    ST_VECTOR = 3'd3,
    ST_REFILL = 3'd4
  } exc_entry_state_t;

  // Link register offsets added to the exception PC.
  localparam logic [31:0] LR_OFS_ARM   = 32'd4;
  localparam logic [31:0] LR_OFS_THUMB = 32'd2;
  localparam logic [31:0] LR_OFS_DABT  = 32'd8;

  // Register file index of the link register.
  localparam logic [3:0] REG_LR = 4'd14;

  // Thumb state bit position in a PSR word.
  localparam int CPSR_T_BIT = 5;

  // Only codes 1..6 describe a real exception.
  function automatic logic exc_type_valid(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd6);
  endfunction

endpackage

// File: rtl/arm7tdmi_exception_entry_if.sv
// Request/strobe bundle between the priority block, the sequencer and the core.
//
// Handshake: a request is a level. The sequencer accepts it on a rising clk edge
// when it is idle, exception_taken=1, instr_boundary=1 and exception_type is 1..6.
// The source keeps the request up until entry_done; there is no ready signal,
// and busy=1 means that no request will be accepted. Every output strobe is a
// one-cycle registered pulse. Its data fields are zero while the strobe is low.
interface arm7tdmi_exception_entry_if;
  logic        exception_taken;
  logic [2:0]  exception_type;
  logic [4:0]  exception_mode;
  logic [31:0] exception_vector;
  logic [31:0] exception_cpsr;
  logic [31:0] exception_spsr;
  logic [31:0] exc_pc;
  logic        instr_boundary;
  logic        fetch_valid;
  logic        busy;
  logic        spsr_wr_en;
  logic [4:0]  spsr_wr_mode;
  logic [31:0] spsr_wr_data;
  logic        cpsr_wr_en;
  logic [31:0] cpsr_wr_data;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [4:0]  rf_wr_mode;
  logic [31:0] rf_wr_data;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        pipe_flush;
  logic        entry_done;
  logic [2:0]  done_type;

  // Sequencer side.
  modport slave (
    input  exception_taken, exception_type, exception_mode, exception_vector,
           exception_cpsr, exception_spsr, exc_pc, instr_boundary, fetch_valid,
    output busy, spsr_wr_en, spsr_wr_mode, spsr_wr_data, cpsr_wr_en, cpsr_wr_data,
           rf_wr_en, rf_wr_addr, rf_wr_mode, rf_wr_data, pc_load, pc_load_addr,
           pipe_flush, entry_done, done_type
  );

  // Request source / core side.
  modport master (
    output exception_taken, exception_type, exception_mode, exception_vector,
           exception_cpsr, exception_spsr, exc_pc, instr_boundary, fetch_valid,
    input  busy, spsr_wr_en, spsr_wr_mode, spsr_wr_data, cpsr_wr_en, cpsr_wr_data,
           rf_wr_en, rf_wr_addr, rf_wr_mode, rf_wr_data, pc_load, pc_load_addr,
           pipe_flush, entry_done, done_type
  );
endinterface

// File: rtl/arm7tdmi_exception_entry_lr_calc.sv
// Combinational link register value: exception PC plus a type-dependent offset.
module arm7tdmi_exception_entry_lr_calc
  import arm7tdmi_exception_entry_pkg::*;
(
  input  exception_type_t i_type,
  input  logic            i_thumb,
  input  logic [31:0]     i_exc_pc,
  output logic [31:0]     o_lr
);

  logic [31:0] w_ofs;

  // Pick the offset; only UND/SWI depend on the Thumb bit of the old CPSR.
  always_comb begin
    w_ofs = LR_OFS_ARM;
    case (i_type)
      EXC_UND, EXC_SWI: w_ofs = i_thumb ? LR_OFS_THUMB : LR_OFS_ARM;
      EXC_DABT:         w_ofs = LR_OFS_DABT;
      default:          w_ofs = LR_OFS_ARM;
    endcase
  end

  // 32-bit modulo add; a PC near the top of memory wraps to low addresses.
  assign o_lr = i_exc_pc + w_ofs;

endmodule

// File: rtl/arm7tdmi_exception_entry.sv
// Exception entry sequencer: bank PSRs, write LR, load the vector, flush the
// pipeline and wait for REFILL_DEPTH fetches before reporting completion.
module arm7tdmi_exception_entry
  import arm7tdmi_exception_entry_pkg::*;
#(
  parameter int REFILL_DEPTH = 2,  // legal 0..7
  parameter int CNT_W        = 3   // must hold REFILL_DEPTH
)
(
  input  logic                        clk,
  input  logic                        rst_n,
  arm7tdmi_exception_entry_if.slave   bus,
  output exc_entry_state_t            o_dbg_state
);

  // Count value at which the final refill fetch arrives.
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((REFILL_DEPTH > 0) ? (REFILL_DEPTH - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  exc_entry_state_t r_state;
  logic [CNT_W-1:0] r_cnt;

  // Values captured at accept, used by the later steps.
  exception_type_t  r_type;
  logic [4:0]       r_mode;
  logic [31:0]      r_vector;
  logic [31:0]      r_lr;

  // Registered outputs.
  logic             r_busy;
  logic             r_spsr_wr_en;
  logic [4:0]       r_spsr_wr_mode;
  logic [31:0]      r_spsr_wr_data;
  logic             r_cpsr_wr_en;
  logic [31:0]      r_cpsr_wr_data;
  logic             r_rf_wr_en;
  logic [3:0]       r_rf_wr_addr;
  logic [4:0]       r_rf_wr_mode;
  logic [31:0]      r_rf_wr_data;
  logic             r_pc_load;
  logic [31:0]      r_pc_load_addr;
  logic             r_pipe_flush;
  logic             r_entry_done;
  logic [2:0]       r_done_type;

  exception_type_t  w_type;
  logic             w_accept;
  logic [31:0]      w_lr;

  assign w_type   = exception_type_t'(bus.exception_type);
  assign w_accept = bus.exception_taken && bus.instr_boundary &&
                    exc_type_valid(bus.exception_type);

  arm7tdmi_exception_entry_lr_calc u_lr_calc (
    .i_type   (w_type),
    .i_thumb  (bus.exception_spsr[CPSR_T_BIT]),
    .i_exc_pc (bus.exc_pc),
    .o_lr     (w_lr)
  );

  // Sequencer FSM; every output is decoded here one cycle ahead of its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_type         <= EXC_NONE;
      r_mode         <= '0;
      r_vector       <= '0;
      r_lr           <= '0;
      r_busy         <= 1'b0;
      r_spsr_wr_en   <= 1'b0;
      r_spsr_wr_mode <= '0;
      r_spsr_wr_data <= '0;
      r_cpsr_wr_en   <= 1'b0;
      r_cpsr_wr_data <= '0;
      r_rf_wr_en     <= 1'b0;
      r_rf_wr_addr   <= '0;
      r_rf_wr_mode   <= '0;
      r_rf_wr_data   <= '0;
      r_pc_load      <= 1'b0;
      r_pc_load_addr <= '0;
      r_pipe_flush   <= 1'b0;
      r_entry_done   <= 1'b0;
      r_done_type    <= '0;
    end else begin
      // Strobes and their data are single-cycle; clear unless re-asserted below.
      r_spsr_wr_en   <= 1'b0;
      r_spsr_wr_mode <= '0;
      r_spsr_wr_data <= '0;
      r_cpsr_wr_en   <= 1'b0;
      r_cpsr_wr_data <= '0;
      r_rf_wr_en     <= 1'b0;
      r_rf_wr_addr   <= '0;
      r_rf_wr_mode   <= '0;
      r_rf_wr_data   <= '0;
      r_pc_load      <= 1'b0;
      r_pc_load_addr <= '0;
      r_pipe_flush   <= 1'b0;
      r_entry_done   <= 1'b0;
      r_done_type    <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_type         <= w_type;
            r_mode         <= bus.exception_mode;
            r_vector       <= bus.exception_vector;
            r_lr           <= w_lr;
            r_state        <= ST_SAVE;
            r_busy         <= 1'b1;
            r_spsr_wr_en   <= 1'b1;
            r_spsr_wr_mode <= bus.exception_mode;
            r_spsr_wr_data <= bus.exception_spsr;
            r_cpsr_wr_en   <= 1'b1;
            r_cpsr_wr_data <= bus.exception_cpsr;
          end
        end
        ST_SAVE: begin
          r_state      <= ST_LINK;
          r_rf_wr_en   <= 1'b1;
          r_rf_wr_addr <= REG_LR;
          r_rf_wr_mode <= r_mode;
          r_rf_wr_data <= r_lr;
        end
        ST_LINK: begin
          r_state        <= ST_VECTOR;
          r_pc_load      <= 1'b1;
          r_pc_load_addr <= r_vector;
          r_pipe_flush   <= 1'b1;
        end
        ST_VECTOR: begin
          if (REFILL_DEPTH == 0) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_entry_done <= 1'b1;
            r_done_type  <= r_type;
          end else begin
            r_state <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (bus.fetch_valid) begin
            if (r_cnt == LAST_CNT) begin
              r_state      <= ST_IDLE;
              r_cnt        <= '0;
              r_busy       <= 1'b0;
              r_entry_done <= 1'b1;
              r_done_type  <= r_type;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.spsr_wr_en   = r_spsr_wr_en;
  assign bus.spsr_wr_mode = r_spsr_wr_mode;
  assign bus.spsr_wr_data = r_spsr_wr_data;
  assign bus.cpsr_wr_en   = r_cpsr_wr_en;
  assign bus.cpsr_wr_data = r_cpsr_wr_data;
  assign bus.rf_wr_en     = r_rf_wr_en;
  assign bus.rf_wr_addr   = r_rf_wr_addr;
  assign bus.rf_wr_mode   = r_rf_wr_mode;
  assign bus.rf_wr_data   = r_rf_wr_data;
  assign bus.pc_load      = r_pc_load;
  assign bus.pc_load_addr = r_pc_load_addr;
  assign bus.pipe_flush   = r_pipe_flush;
  assign bus.entry_done   = r_entry_done;
  assign bus.done_type    = r_done_type;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_arm7tdmi_exception_entry.sv
// Directed bench for the exception entry sequencer (REFILL_DEPTH 2 and 0).
module tb_arm7tdmi_exception_entry;
  import arm7tdmi_exception_entry_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arm7tdmi_exception_entry_if bus_if ();
  arm7tdmi_exception_entry_if bus0_if ();
  exc_entry_state_t dbg_state;
  exc_entry_state_t dbg_state0;

  arm7tdmi_exception_entry #(.REFILL_DEPTH(2), .CNT_W(3)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state)
  );

  arm7tdmi_exception_entry #(.REFILL_DEPTH(0), .CNT_W(3)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus0_if.slave),
    .o_dbg_state (dbg_state0)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];  // expected done_type of each entry that must complete

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: completion pulses ----------------
  always @(negedge clk) begin
    if (rst_n && bus_if.entry_done === 1'b1) begin
      if (exp_q.size() == 0) check_eq("unexpected_entry_done", 32'd1, 32'd0);
      else check_eq("done_type_sb", {29'd0, bus_if.done_type}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.exception_taken  = 1'b0;
    bus_if.exception_type   = 3'd0;
    bus_if.exception_mode   = 5'd0;
    bus_if.exception_vector = 32'd0;
    bus_if.exception_cpsr   = 32'd0;
    bus_if.exception_spsr   = 32'd0;
    bus_if.exc_pc           = 32'd0;
    bus_if.instr_boundary   = 1'b0;
    bus_if.fetch_valid      = 1'b0;
  endtask

  task automatic clear_inputs0();
    bus0_if.exception_taken  = 1'b0;
    bus0_if.exception_type   = 3'd0;
    bus0_if.exception_mode   = 5'd0;
    bus0_if.exception_vector = 32'd0;
    bus0_if.exception_cpsr   = 32'd0;
    bus0_if.exception_spsr   = 32'd0;
    bus0_if.exc_pc           = 32'd0;
    bus0_if.instr_boundary   = 1'b0;
    bus0_if.fetch_valid      = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] t, input logic [4:0] mode, input logic [31:0] vec,
                         input logic [31:0] cpsr, input logic [31:0] spsr, input logic [31:0] pc);
    bus_if.exception_type   = t;
    bus_if.exception_mode   = mode;
    bus_if.exception_vector = vec;
    bus_if.exception_cpsr   = cpsr;
    bus_if.exception_spsr   = spsr;
    bus_if.exc_pc           = pc;
    bus_if.exception_taken  = 1'b1;
    bus_if.instr_boundary   = 1'b1;
  endtask

  // Full entry on the depth-2 instance. hold keeps a (changed) request asserted
  // through the sequence; gap is the idle cycles before each fetch_valid pulse.
  task automatic run_entry(input string nm, input logic [2:0] t, input logic [4:0] mode,
                           input logic [31:0] vec, input logic [31:0] cpsr,
                           input logic [31:0] spsr, input logic [31:0] pc,
                           input logic [31:0] exp_lr, input int gap, input bit hold);
    int cyc;
    exp_q.push_back({29'd0, t});
    set_req(t, mode, vec, cpsr, spsr, pc);
    tick();
    cyc = 1;
    if (hold) begin
      bus_if.exception_type   = 3'd6;
      bus_if.exception_mode   = 5'h11;
      bus_if.exception_vector = 32'h0000_0BAD;
      bus_if.exception_cpsr   = 32'h0;
      bus_if.exception_spsr   = 32'h20;
      bus_if.exc_pc           = 32'hDEAD_0000;
    end else begin
      bus_if.exception_taken = 1'b0;
    end
    // SAVE
    check_eq({nm, "_save_state"}, {29'd0, dbg_state}, {29'd0, ST_SAVE});
    check_eq({nm, "_save_busy"}, {31'd0, bus_if.busy}, 32'd1);
    check_eq({nm, "_spsr_en"}, {31'd0, bus_if.spsr_wr_en}, 32'd1);
    check_eq({nm, "_spsr_mode"}, {27'd0, bus_if.spsr_wr_mode}, {27'd0, mode});
    check_eq({nm, "_spsr_data"}, bus_if.spsr_wr_data, spsr);
    check_eq({nm, "_cpsr_en"}, {31'd0, bus_if.cpsr_wr_en}, 32'd1);
    check_eq({nm, "_cpsr_data"}, bus_if.cpsr_wr_data, cpsr);
    check_eq({nm, "_save_rf_en"}, {31'd0, bus_if.rf_wr_en}, 32'd0);
    tick();
    cyc++;
    // LINK
    check_eq({nm, "_rf_en"}, {31'd0, bus_if.rf_wr_en}, 32'd1);
    check_eq({nm, "_rf_addr"}, {28'd0, bus_if.rf_wr_addr}, 32'd14);
    check_eq({nm, "_rf_mode"}, {27'd0, bus_if.rf_wr_mode}, {27'd0, mode});
    check_eq({nm, "_lr"}, bus_if.rf_wr_data, exp_lr);
    check_eq({nm, "_link_spsr_en"}, {31'd0, bus_if.spsr_wr_en}, 32'd0);
    check_eq({nm, "_link_cpsr_data"}, bus_if.cpsr_wr_data, 32'd0);
    tick();
    cyc++;
    // VECTOR
    check_eq({nm, "_pc_load"}, {31'd0, bus_if.pc_load}, 32'd1);
    check_eq({nm, "_pc_addr"}, bus_if.pc_load_addr, vec);
    check_eq({nm, "_flush"}, {31'd0, bus_if.pipe_flush}, 32'd1);
    check_eq({nm, "_vec_rf_data"}, bus_if.rf_wr_data, 32'd0);
    tick();
    cyc++;
    // REFILL
    check_eq({nm, "_refill_busy"}, {31'd0, bus_if.busy}, 32'd1);
    check_eq({nm, "_refill_pc_load"}, {31'd0, bus_if.pc_load}, 32'd0);
    check_eq({nm, "_refill_addr"}, bus_if.pc_load_addr, 32'd0);
    for (int p = 0; p < 2; p++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        cyc++;
        check_eq({nm, "_gap_busy"}, {31'd0, bus_if.busy}, 32'd1);
        check_eq({nm, "_gap_done"}, {31'd0, bus_if.entry_done}, 32'd0);
      end
      bus_if.fetch_valid = 1'b1;
      tick();
      cyc++;
      bus_if.fetch_valid = 1'b0;
      if (p == 0) begin
        check_eq({nm, "_mid_busy"}, {31'd0, bus_if.busy}, 32'd1);
        check_eq({nm, "_mid_done"}, {31'd0, bus_if.entry_done}, 32'd0);
      end
    end
    if (hold) bus_if.exception_taken = 1'b0;
    // First IDLE cycle
    check_eq({nm, "_done"}, {31'd0, bus_if.entry_done}, 32'd1);
    check_eq({nm, "_done_type"}, {29'd0, bus_if.done_type}, {29'd0, t});
    check_eq({nm, "_done_busy"}, {31'd0, bus_if.busy}, 32'd0);
    check_eq({nm, "_latency"}, cyc, 6 + 2 * gap);
    tick();
    check_eq({nm, "_done_pulse"}, {31'd0, bus_if.entry_done}, 32'd0);
    check_eq({nm, "_no_reaccept"}, {31'd0, bus_if.spsr_wr_en}, 32'd0);
    clear_inputs();
    tick();
  endtask

  // Hold a request for a few cycles and require that nothing starts.
  task automatic expect_ignored(input string nm);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq({nm, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
      check_eq({nm, "_spsr_en"}, {31'd0, bus_if.spsr_wr_en}, 32'd0);
    end
    clear_inputs();
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_inputs();
    clear_inputs0();
    #12;
    check_eq("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check_eq("rst_spsr_en", {31'd0, bus_if.spsr_wr_en}, 32'd0);
    check_eq("rst_cpsr_en", {31'd0, bus_if.cpsr_wr_en}, 32'd0);
    check_eq("rst_rf_en", {31'd0, bus_if.rf_wr_en}, 32'd0);
    check_eq("rst_rf_addr", {28'd0, bus_if.rf_wr_addr}, 32'd0);
    check_eq("rst_pc_load", {31'd0, bus_if.pc_load}, 32'd0);
    check_eq("rst_flush", {31'd0, bus_if.pipe_flush}, 32'd0);
    check_eq("rst_done", {31'd0, bus_if.entry_done}, 32'd0);
    check_eq("rst_done_type", {29'd0, bus_if.done_type}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    //        name      type  mode   vector        cpsr          spsr          exc_pc        lr            gap hold
    run_entry("swi_arm", 3'd2, 5'h13, 32'h0000_0008, 32'h0000_0093, 32'h0000_0010, 32'h0000_0100, 32'h0000_0104, 0, 1'b0);
    run_entry("swi_thb", 3'd2, 5'h13, 32'h0000_0008, 32'h0000_0093, 32'h0000_0030, 32'h0000_0202, 32'h0000_0204, 0, 1'b0);
    run_entry("dabt",    3'd4, 5'h17, 32'h0000_0010, 32'h0000_0097, 32'h0000_0010, 32'h0000_2000, 32'h0000_2008, 0, 1'b1);
    run_entry("fiq",     3'd6, 5'h11, 32'h0000_001C, 32'h0000_00D1, 32'h0000_0010, 32'hFFFF_FFFC, 32'h0000_0000, 2, 1'b0);
    run_entry("pabt",    3'd3, 5'h17, 32'h0000_000C, 32'h0000_0097, 32'h0000_0030, 32'h0000_3000, 32'h0000_3004, 1, 1'b0);
    run_entry("und_thb", 3'd1, 5'h1B, 32'h0000_0004, 32'h0000_009B, 32'h0000_0030, 32'h0000_0600, 32'h0000_0602, 0, 1'b0);

    // Request without an instruction boundary.
    set_req(3'd5, 5'h12, 32'h18, 32'h92, 32'h10, 32'h400);
    bus_if.instr_boundary = 1'b0;
    expect_ignored("no_boundary");
    // Type 0 at a boundary.
    set_req(3'd0, 5'h12, 32'h18, 32'h92, 32'h10, 32'h400);
    expect_ignored("type0");

    // REFILL_DEPTH=0 instance: VECTOR returns straight to IDLE.
    bus0_if.exception_type   = 3'd5;
    bus0_if.exception_mode   = 5'h12;
    bus0_if.exception_vector = 32'h18;
    bus0_if.exception_cpsr   = 32'h92;
    bus0_if.exception_spsr   = 32'h10;
    bus0_if.exc_pc           = 32'h400;
    bus0_if.exception_taken  = 1'b1;
    bus0_if.instr_boundary   = 1'b1;
    tick();
    bus0_if.exception_taken = 1'b0;
    check_eq("d0_spsr_en", {31'd0, bus0_if.spsr_wr_en}, 32'd1);
    tick();
    check_eq("d0_lr", bus0_if.rf_wr_data, 32'h404);
    tick();
    check_eq("d0_pc_load", {31'd0, bus0_if.pc_load}, 32'd1);
    check_eq("d0_pc_addr", bus0_if.pc_load_addr, 32'h18);
    tick();
    check_eq("d0_state", {29'd0, dbg_state0}, {29'd0, ST_IDLE});
    check_eq("d0_busy", {31'd0, bus0_if.busy}, 32'd0);
    check_eq("d0_done", {31'd0, bus0_if.entry_done}, 32'd1);
    check_eq("d0_done_type", {29'd0, bus0_if.done_type}, 32'd5);
    tick();
    check_eq("d0_done_pulse", {31'd0, bus0_if.entry_done}, 32'd0);
    clear_inputs0();

    // Reset asserted during LINK aborts the entry.
    set_req(3'd1, 5'h1B, 32'h04, 32'h9B, 32'h10, 32'h500);
    tick();
    bus_if.exception_taken = 1'b0;
    tick();
    check_eq("rmid_link_rf_en", {31'd0, bus_if.rf_wr_en}, 32'd1);
    check_eq("rmid_link_lr", bus_if.rf_wr_data, 32'h504);
    rst_n = 1'b0;
    #1;
    check_eq("rmid_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("rmid_rf_en", {31'd0, bus_if.rf_wr_en}, 32'd0);
    check_eq("rmid_rf_data", bus_if.rf_wr_data, 32'd0);
    check_eq("rmid_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      bus_if.fetch_valid = i[0];
      tick();
      check_eq("rpost_pc_load", {31'd0, bus_if.pc_load}, 32'd0);
      check_eq("rpost_busy", {31'd0, bus_if.busy}, 32'd0);
    end
    bus_if.fetch_valid = 1'b0;
    tick();
    run_entry("irq_post_rst", 3'd5, 5'h12, 32'h0000_0018, 32'h0000_0092, 32'h0000_0010, 32'h0000_0400, 32'h0000_0404, 0, 1'b0);

    repeat (3) tick();
    check_eq("sb_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
